reg_wb_arbiter: RTL and testbench

Write-back controller in front of the integer register file. It shares the file's single write port between the ALU and load/store write-back requesters using round-robin arbitration and a one-entry registered output stage. It also keeps a 32-entry busy-bit scoreboard that the decode stage queries for read-after-write hazards. It sits between the execute/memory stages and `reg_file`, and drives that block's `reg_wen`/`reg_waddr`/`reg_wdata`/`wmask`.

---
 rtl/reg_wb_arbiter_pkg.sv | 26 ++
 rtl/reg_wb_arbiter_if.sv | 48 ++++
 rtl/reg_wb_arbiter_scoreboard.sv | 54 +++++
 rtl/reg_wb_arbiter.sv | 91 +++++++++
 tb/tb_reg_wb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths, requester encoding and helpers for the register-file
// write-back controller.
package reg_wb_arbiter_pkg;

    localparam int CPU_WIDTH      = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_DEPTH = 32;

    localparam logic [7:0] WMASK_FULL = 8'hFF;
    localparam logic [7:0] WMASK_NONE = 8'h00;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [CPU_WIDTH-1:0]      reg_data_t;
    typedef logic [REG_DATA_DEPTH-1:0] busy_vec_t;

    // Requester index; also the round-robin preference encoding.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    function automatic wb_src_e wb_src_other(input wb_src_e src);
        return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the write-back requests, scoreboard query/issue signals and the
// register-file write port seen by reg_wb_arbiter.
interface reg_wb_arbiter_if;
    import reg_wb_arbiter_pkg::*;

    logic      alu_wb_valid;
    logic      alu_wb_ready;
    reg_addr_t alu_wb_addr;
    reg_data_t alu_wb_data;

    logic      lsu_wb_valid;
    logic      lsu_wb_ready;
    reg_addr_t lsu_wb_addr;
    reg_data_t lsu_wb_data;

    logic      rf_busy;
    logic      issue_valid;
    reg_addr_t issue_rd;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_hazard;
    logic      rs2_hazard;
    logic      flush;

    logic      reg_wen;
    reg_addr_t reg_waddr;
    reg_data_t reg_wdata;
    logic [7:0] wmask;

    // Pipeline side: drives requests and queries.
    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output rf_busy, issue_valid, issue_rd, rs1_addr, rs2_addr, flush,
        input  alu_wb_ready, lsu_wb_ready, rs1_hazard, rs2_hazard,
        input  reg_wen, reg_waddr, reg_wdata, wmask
    );

    // Controller side.
    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  rf_busy, issue_valid, issue_rd, rs1_addr, rs2_addr, flush,
        output alu_wb_ready, lsu_wb_ready, rs1_hazard, rs2_hazard,
        output reg_wen, reg_waddr, reg_wdata, wmask
    );

endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue,
// cleared on commit, pruned on flush, with two combinational hazard ports.
module wb_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_set_valid,
    input  reg_addr_t i_set_addr,
    input  logic      i_clr_valid,
    input  reg_addr_t i_clr_addr,
    input  logic      i_flush,
    input  logic      i_keep_valid,
    input  reg_addr_t i_keep_addr,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    output logic      o_rs1_hazard,
    output logic      o_rs2_hazard
);

    busy_vec_t r_busy;
    busy_vec_t w_busy_next;
    busy_vec_t w_keep_mask;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_keep_mask              = '0;
        w_keep_mask[i_keep_addr] = i_keep_valid;
        w_busy_next              = r_busy;
        // Only the write still sitting in the output stage survives a flush.
        if (i_flush)
            w_busy_next = r_busy & w_keep_mask;
        if (i_clr_valid)
            w_busy_next[i_clr_addr] = 1'b0;
        // Applied after the clear: a newer producer of the same register wins.
        if (i_set_valid && !i_flush)
            w_busy_next[i_set_addr] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign o_rs1_hazard = r_busy[i_rs1_addr];
    assign o_rs2_hazard = r_busy[i_rs2_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back controller: round-robin arbitration of ALU/LSU results into a
// one-entry output stage that drives the register-file write port.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    reg_wb_arbiter_if.slave   bus
);

    logic      r_out_valid;
    reg_addr_t r_out_addr;
    reg_data_t r_out_data;
    wb_src_e   r_rr;

    wb_src_e   w_rr_next;
    logic      w_can_accept;
    logic      w_alu_grant;
    logic      w_lsu_grant;
    logic      w_drain;
    logic      w_commit;
    reg_addr_t w_sel_addr;
    reg_data_t w_sel_data;

    assign w_can_accept = !r_out_valid || !bus.rf_busy;
    // An occupied stage empties when the file is free, x0 entries included.
    assign w_drain      = r_out_valid && !bus.rf_busy;
    assign w_commit     = w_drain && (r_out_addr != '0);

    always_comb begin
        w_alu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        w_rr_next   = r_rr;
        if (!bus.flush && w_can_accept) begin
            if (bus.alu_wb_valid && bus.lsu_wb_valid) begin
                w_alu_grant = (r_rr == WB_SRC_ALU);
                w_lsu_grant = (r_rr == WB_SRC_LSU);
            end else begin
                w_alu_grant = bus.alu_wb_valid;
                w_lsu_grant = bus.lsu_wb_valid;
            end
        end
        if (w_alu_grant || w_lsu_grant)
            w_rr_next = wb_src_other(w_alu_grant ? WB_SRC_ALU : WB_SRC_LSU);
    end

    assign w_sel_addr = w_alu_grant ? bus.alu_wb_addr : bus.lsu_wb_addr;
    assign w_sel_data = w_alu_grant ? bus.alu_wb_data : bus.lsu_wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= WB_SRC_ALU;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_rr <= w_rr_next;
            if (w_alu_grant || w_lsu_grant) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= w_sel_addr;
                r_out_data  <= w_sel_data;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_wb_ready = w_alu_grant;
    assign bus.lsu_wb_ready = w_lsu_grant;
    assign bus.reg_wen      = w_commit;
    assign bus.reg_waddr    = r_out_addr;
    assign bus.reg_wdata    = r_out_data;
    assign bus.wmask        = w_commit ? WMASK_FULL : WMASK_NONE;

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set_valid  (bus.issue_valid && (bus.issue_rd != '0)),
        .i_set_addr   (bus.issue_rd),
        .i_clr_valid  (w_commit),
        .i_clr_addr   (r_out_addr),
        .i_flush      (bus.flush),
        .i_keep_valid (r_out_valid),
        .i_keep_addr  (r_out_addr),
        .i_rs1_addr   (bus.rs1_addr),
        .i_rs2_addr   (bus.rs2_addr),
        .o_rs1_hazard (bus.rs1_hazard),
        .o_rs2_hazard (bus.rs2_hazard)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a scoreboard queue predicts every
// register-file write from the accepted requests; directed steps check the rest.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    wb_src_e exp_src;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Commits are popped before this cycle's grants are pushed.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.reg_wen) begin
                if (exp_q.size() == 0) begin
                    check1("wb_unexpected", bus.reg_wen, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_addr", 64'(bus.reg_waddr), 64'(mon_e.addr));
                    check("wb_data", bus.reg_wdata, mon_e.data);
                    check("wb_mask", 64'(bus.wmask), 64'hFF);
                end
            end
            if (bus.alu_wb_valid && bus.alu_wb_ready && bus.alu_wb_addr != '0)
                exp_q.push_back('{addr: bus.alu_wb_addr, data: bus.alu_wb_data});
            if (bus.lsu_wb_valid && bus.lsu_wb_ready && bus.lsu_wb_addr != '0)
                exp_q.push_back('{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data});
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.alu_wb_valid = 1'b0; bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
        bus.lsu_wb_valid = 1'b0; bus.lsu_wb_addr = '0; bus.lsu_wb_data = '0;
        bus.rf_busy = 1'b0; bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0; bus.flush = 1'b0;

        // Reset state
        at_neg();
        check1("rst_wen", bus.reg_wen, 1'b0);
        check("rst_waddr", 64'(bus.reg_waddr), 64'd0);
        check("rst_wdata", bus.reg_wdata, 64'd0);
        check("rst_wmask", 64'(bus.wmask), 64'd0);
        check1("rst_alu_rdy", bus.alu_wb_ready, 1'b0);
        check1("rst_lsu_rdy", bus.lsu_wb_ready, 1'b0);
        check1("rst_haz1", bus.rs1_hazard, 1'b0);
        check1("rst_haz2", bus.rs2_hazard, 1'b0);
        tick();
        rst_n = 1'b1;

        // Single ALU write to x5 after issuing x5
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        at_neg(); tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr = 5'd5;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd5; bus.alu_wb_data = 64'h1234;
        at_neg();
        check1("s_haz_before", bus.rs1_hazard, 1'b1);
        check1("s_alu_rdy", bus.alu_wb_ready, 1'b1);
        check1("s_lsu_rdy", bus.lsu_wb_ready, 1'b0);
        tick();
        bus.alu_wb_valid = 1'b0;
        at_neg();
        check1("s_wen", bus.reg_wen, 1'b1);
        check("s_waddr", 64'(bus.reg_waddr), 64'd5);
        check("s_wdata", bus.reg_wdata, 64'h1234);
        check("s_wmask", 64'(bus.wmask), 64'hFF);
        check1("s_haz_commit", bus.rs1_hazard, 1'b1);
        tick();
        at_neg();
        check1("s_wen_off", bus.reg_wen, 1'b0);
        check("s_wmask_off", 64'(bus.wmask), 64'd0);
        check1("s_haz_after", bus.rs1_hazard, 1'b0);
        tick();

        // Contention: the ALU grant above leaves the LSU preferred
        exp_src = WB_SRC_LSU;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd1; bus.alu_wb_data = 64'hA000;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd2; bus.lsu_wb_data = 64'hB000;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            check1("c_alu_rdy", bus.alu_wb_ready, exp_src == WB_SRC_ALU);
            check1("c_lsu_rdy", bus.lsu_wb_ready, exp_src == WB_SRC_LSU);
            if (i > 0) check1("c_wen", bus.reg_wen, 1'b1);
            tick();
            if (exp_src == WB_SRC_ALU) bus.alu_wb_data = bus.alu_wb_data + 64'd1;
            else                       bus.lsu_wb_data = bus.lsu_wb_data + 64'd1;
            exp_src = wb_src_other(exp_src);
        end
        bus.alu_wb_valid = 1'b0; bus.lsu_wb_valid = 1'b0;
        at_neg();
        check1("c_wen_last", bus.reg_wen, 1'b1);
        tick();

        // Back-pressure: x10 held for three busy cycles
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd10; bus.alu_wb_data = 64'hDEAD_BEEF;
        at_neg();
        check1("b_alu_rdy", bus.alu_wb_ready, 1'b1);
        tick();
        exp_src = WB_SRC_LSU;
        bus.rf_busy = 1'b1;
        bus.alu_wb_addr = 5'd11; bus.alu_wb_data = 64'h1111;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd12; bus.lsu_wb_data = 64'h2222;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check1("b_wen_hold", bus.reg_wen, 1'b0);
            check1("b_alu_hold", bus.alu_wb_ready, 1'b0);
            check1("b_lsu_hold", bus.lsu_wb_ready, 1'b0);
            check("b_waddr_hold", 64'(bus.reg_waddr), 64'd10);
            check("b_wdata_hold", bus.reg_wdata, 64'hDEAD_BEEF);
            tick();
        end
        bus.rf_busy = 1'b0;
        at_neg();
        check1("b_wen_rel", bus.reg_wen, 1'b1);
        check("b_wdata_rel", bus.reg_wdata, 64'hDEAD_BEEF);
        check1("b_lsu_rdy", bus.lsu_wb_ready, exp_src == WB_SRC_LSU);
        check1("b_alu_rdy2", bus.alu_wb_ready, exp_src == WB_SRC_ALU);
        tick();
        bus.lsu_wb_valid = 1'b0;
        at_neg();
        check("b_waddr_12", 64'(bus.reg_waddr), 64'd12);
        check1("b_alu_rdy3", bus.alu_wb_ready, 1'b1);
        tick();
        bus.alu_wb_valid = 1'b0;
        at_neg();
        check("b_waddr_11", 64'(bus.reg_waddr), 64'd11);
        tick();
        at_neg();
        check1("b_wen_idle", bus.reg_wen, 1'b0);
        tick();

        // Scoreboard: x7 hazard lifetime, and re-issue racing the commit
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        at_neg(); tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr = 5'd7;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd7; bus.alu_wb_data = 64'h77;
        at_neg();
        check1("h_haz_issued", bus.rs1_hazard, 1'b1);
        check1("h_alu_rdy", bus.alu_wb_ready, 1'b1);
        tick();
        bus.alu_wb_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        at_neg();
        check1("h_wen", bus.reg_wen, 1'b1);
        check1("h_haz_commit", bus.rs1_hazard, 1'b1);
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_data = 64'h78;
        at_neg();
        check1("h_haz_setwins", bus.rs1_hazard, 1'b1);
        tick();
        bus.alu_wb_valid = 1'b0;
        at_neg();
        check1("h_haz_commit2", bus.rs1_hazard, 1'b1);
        tick();
        at_neg();
        check1("h_haz_clear", bus.rs1_hazard, 1'b0);
        tick();

        // x0 write: accepted but never written
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs2_addr = 5'd0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd0; bus.alu_wb_data = 64'hFFFF;
        at_neg();
        check1("z_alu_rdy", bus.alu_wb_ready, 1'b1);
        check1("z_haz", bus.rs2_hazard, 1'b0);
        tick();
        bus.issue_valid = 1'b0; bus.alu_wb_valid = 1'b0;
        at_neg();
        check1("z_wen", bus.reg_wen, 1'b0);
        check1("z_haz2", bus.rs2_hazard, 1'b0);
        tick();
        at_neg();
        check1("z_wen2", bus.reg_wen, 1'b0);
        tick();

        // Flush with an empty output stage blocks both requesters
        bus.flush = 1'b1;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd4; bus.alu_wb_data = 64'h44;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd5; bus.lsu_wb_data = 64'h55;
        at_neg();
        check1("f0_alu_rdy", bus.alu_wb_ready, 1'b0);
        check1("f0_lsu_rdy", bus.lsu_wb_ready, 1'b0);
        tick();
        bus.flush = 1'b0; bus.alu_wb_valid = 1'b0; bus.lsu_wb_valid = 1'b0;

        // Flush with x3, x9 busy and x9 held in the output stage
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        at_neg(); tick();
        bus.issue_rd = 5'd9;
        at_neg(); tick();
        bus.issue_valid = 1'b0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd9; bus.alu_wb_data = 64'h99;
        at_neg();
        check1("f_alu_rdy", bus.alu_wb_ready, 1'b1);
        tick();
        bus.flush = 1'b1; bus.rf_busy = 1'b1;
        bus.alu_wb_addr = 5'd4; bus.alu_wb_data = 64'h44;
        bus.lsu_wb_valid = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd9;
        at_neg();
        check1("f_alu_rdy0", bus.alu_wb_ready, 1'b0);
        check1("f_lsu_rdy0", bus.lsu_wb_ready, 1'b0);
        check1("f_wen0", bus.reg_wen, 1'b0);
        check1("f_haz3_pre", bus.rs1_hazard, 1'b1);
        check1("f_haz9_pre", bus.rs2_hazard, 1'b1);
        tick();
        bus.flush = 1'b0; bus.rf_busy = 1'b0;
        bus.alu_wb_valid = 1'b0; bus.lsu_wb_valid = 1'b0; bus.issue_valid = 1'b0;
        at_neg();
        check1("f_wen9", bus.reg_wen, 1'b1);
        check("f_waddr9", 64'(bus.reg_waddr), 64'd9);
        check1("f_haz3_clr", bus.rs1_hazard, 1'b0);
        check1("f_haz9_kept", bus.rs2_hazard, 1'b1);
        bus.rs1_addr = 5'd6;
        #1;
        check1("f_haz6_ignored", bus.rs1_hazard, 1'b0);
        tick();
        at_neg();
        check1("f_haz9_clr", bus.rs2_hazard, 1'b0);
        tick();

        // Reset in the middle of a stalled write discards it
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd8;
        at_neg(); tick();
        bus.issue_valid = 1'b0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd8; bus.alu_wb_data = 64'h88;
        at_neg();
        check1("r_alu_rdy", bus.alu_wb_ready, 1'b1);
        tick();
        bus.alu_wb_valid = 1'b0; bus.rf_busy = 1'b1; bus.rs1_addr = 5'd8;
        at_neg();
        check1("r_haz_pre", bus.rs1_hazard, 1'b1);
        check("r_waddr_pre", 64'(bus.reg_waddr), 64'd8);
        #1;
        rst_n = 1'b0;
        #1;
        check("r_waddr_rst", 64'(bus.reg_waddr), 64'd0);
        check("r_wdata_rst", bus.reg_wdata, 64'd0);
        check1("r_haz_rst", bus.rs1_hazard, 1'b0);
        tick();
        at_neg();
        tick();
        rst_n = 1'b1; bus.rf_busy = 1'b0;
        at_neg();
        check1("r_wen_after", bus.reg_wen, 1'b0);
        tick();
        at_neg();
        check1("r_wen_after2", bus.reg_wen, 1'b0);
        check("q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
